// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel input debouncer.
// Each channel passes through a 2-FF synchroniser. A shared prescaler produces
// a sample tick, and on every tick each channel's stability counter advances
// while the synchronised input disagrees with the debounced output. Once
// STABLE_CNT consecutive disagreeing samples have been seen, the output flips
// and a one-cycle rise or fall strobe is issued. Any agreeing sample clears
// the count, so short glitches are rejected.
// en=0 freezes the prescaler and the filters, so outputs and counts hold.
module debounce_bank #(
  parameter int              NCH        = 8,
  parameter int              DIV_W      = 16,
  parameter int              TICK_DIV   = 49999,
  parameter int              STABLE_CNT = 4,
  parameter int              CNT_W      = 3,
  parameter logic [NCH-1:0]  RESET_VAL  = {NCH{1'b1}}
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [NCH-1:0] sig_i,
  output logic [NCH-1:0] sig_o,
  output logic [NCH-1:0] rise_o,
  output logic [NCH-1:0] fall_o,
  output logic           tick_o
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV);
  localparam logic [CNT_W:0]   CNT_LAST = (CNT_W + 1)'(STABLE_CNT);

  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [CNT_W-1:0] cnt [NCH];

  // A tick occurs in the last cycle of each prescaler period, and only while enabled.
  assign tick = en && (div_cnt == DIV_LAST);

  // Two-stage synchroniser; it starts at the idle level so reset produces no spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= sig_i;
      sync2 <= sync1;
    end
  end

  // Shared prescaler counting 0..TICK_DIV, plus a registered copy of the tick for monitoring.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      tick_o  <= 1'b0;
    end else begin
      tick_o <= tick;
      if (en) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
    end
  end

  // Per-channel consecutive-sample filter. The strobes default low and rise only when sig_o flips.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_o  <= RESET_VAL;
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        rise_o[i] <= 1'b0;
        fall_o[i] <= 1'b0;
        if (tick) begin
          if (sync2[i] == sig_o[i]) begin
            cnt[i] <= '0;
          end else if (({1'b0, cnt[i]} + 1'b1) == CNT_LAST) begin
            sig_o[i]  <= sync2[i];
            cnt[i]    <= '0;
            rise_o[i] <= sync2[i];
            fall_o[i] <= ~sync2[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule
